ram_bist_master: RTL

Bus initiator and built-in self-test engine for the 8x16 RAM port. It drives the valid/wr_rd/add/writedata request side and consumes readdata/ready. On a start pulse it runs four passes over every location: write pattern, read-verify, write inverted pattern, read-verify. It then reports the error count, the first failing address and pass/fail to the system controller.

---
 rtl/ram_bist_master.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ram_bist_master.sv
// ram_bist_master: bus initiator and march-style self test for a small RAM port.
// Four passes over every location: write P(a), read-verify, write ~P(a),
// read-verify, then a one-cycle flush so the final read compare can land.
// Every output is a flop; nothing combinational runs from an input to an output.
module ram_bist_master #(
  parameter int DATABIT      = 8,
  parameter int NOOFLOCATION = 16,
  parameter int ADDRESSBIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATABIT-1:0]    seed,
  output logic                  valid,
  output logic                  wr_rd,
  output logic [ADDRESSBIT-1:0] add,
  output logic [DATABIT-1:0]    writedata,
  input  logic [DATABIT-1:0]    readdata,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDRESSBIT+1:0] err_count,
  output logic [ADDRESSBIT-1:0] first_err_addr,
  output logic                  first_err_phase
);

  typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, FLUSH} state_t;

  localparam logic [ADDRESSBIT-1:0] LAST_ADDR = ADDRESSBIT'(NOOFLOCATION - 1);
  localparam logic [ADDRESSBIT-1:0] ADDR_ONE  = ADDRESSBIT'(1);
  localparam logic [ADDRESSBIT+1:0] ERR_ONE   = (ADDRESSBIT+2)'(1);

  state_t state_q, state_d;

  logic                  valid_q, valid_d;
  logic                  wr_rd_q, wr_rd_d;
  logic [ADDRESSBIT-1:0] add_q, add_d;
  logic [DATABIT-1:0]    writedata_q, writedata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [ADDRESSBIT+1:0] err_q, err_d;
  logic [ADDRESSBIT-1:0] fea_q, fea_d;
  logic                  fep_q, fep_d;
  logic [DATABIT-1:0]    seed_q, seed_d;

  // Read-compare pipeline: expectation captured on the read accept edge,
  // checked against readdata on the following edge.
  logic                  cmp_pend_q, cmp_pend_d;
  logic [DATABIT-1:0]    exp_q, exp_d;
  logic [ADDRESSBIT-1:0] caddr_q, caddr_d;
  logic                  cphase_q, cphase_d;

  logic accept;
  logic mismatch;

  // Pattern for address a: seed plus zero-extended address, optionally inverted.
  function automatic logic [DATABIT-1:0] pat(input logic [DATABIT-1:0]    s,
                                             input logic [ADDRESSBIT-1:0] a,
                                             input logic                  inv);
    logic [DATABIT-1:0] p;
    p = s + DATABIT'(a);
    return inv ? ~p : p;
  endfunction

  // Next-state, bus sequencing and result bookkeeping.
  always_comb begin
    state_d     = state_q;
    add_d       = add_q;
    writedata_d = writedata_q;
    seed_d      = seed_q;
    done_d      = done_q;
    err_d       = err_q;
    fea_d       = fea_q;
    fep_d       = fep_q;
    cmp_pend_d  = 1'b0;
    exp_d       = exp_q;
    caddr_d     = caddr_q;
    cphase_d    = cphase_q;

    accept   = valid_q && ready;
    mismatch = cmp_pend_q && (readdata != exp_q);

    // Land the compare for the read accepted on the previous edge.
    if (mismatch) begin
      err_d = err_q + ERR_ONE;
      if (err_q == '0) begin
        fea_d = caddr_q;
        fep_d = cphase_q;
      end
    end

    // Capture the expectation for a read accepted on this edge.
    if (accept && !wr_rd_q) begin
      cmp_pend_d = 1'b1;
      exp_d      = pat(seed_q, add_q, state_q == RD1);
      caddr_d    = add_q;
      cphase_d   = (state_q == RD1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = WR0;
          add_d       = '0;
          seed_d      = seed;
          writedata_d = seed;
          done_d      = 1'b0;
          err_d       = '0;
          fea_d       = '0;
          fep_d       = 1'b0;
        end
      end
      WR0, RD0, WR1, RD1: begin
        if (accept) begin
          if (add_q == LAST_ADDR) begin
            add_d = '0;
            case (state_q)
              WR0:     state_d = RD0;
              RD0:     state_d = WR1;
              WR1:     state_d = RD1;
              default: state_d = FLUSH;
            endcase
            // Preload the first inverted word as the bus turns to WR1.
            if (state_q == RD0) writedata_d = pat(seed_q, '0, 1'b1);
          end else begin
            add_d = add_q + ADDR_ONE;
            if (wr_rd_q) writedata_d = pat(seed_q, add_q + ADDR_ONE, state_q == WR1);
          end
        end
      end
      FLUSH: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == WR0) || (state_d == RD0) || (state_d == WR1) || (state_d == RD1);
    wr_rd_d = (state_d == WR0) || (state_d == WR1);
    busy_d  = (state_d != IDLE);
    pass_d  = done_d && (err_d == '0);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      wr_rd_q     <= 1'b0;
      add_q       <= '0;
      writedata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fea_q       <= '0;
      fep_q       <= 1'b0;
      seed_q      <= '0;
      cmp_pend_q  <= 1'b0;
      exp_q       <= '0;
      caddr_q     <= '0;
      cphase_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      wr_rd_q     <= wr_rd_d;
      add_q       <= add_d;
      writedata_q <= writedata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fea_q       <= fea_d;
      fep_q       <= fep_d;
      seed_q      <= seed_d;
      cmp_pend_q  <= cmp_pend_d;
      exp_q       <= exp_d;
      caddr_q     <= caddr_d;
      cphase_q    <= cphase_d;
    end
  end

  assign valid           = valid_q;
  assign wr_rd           = wr_rd_q;
  assign add             = add_q;
  assign writedata       = writedata_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_addr  = fea_q;
  assign first_err_phase = fep_q;

endmodule
